// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU with overflow detection, multi-cycle
// HI/LO multiply/divide unit and the registered EX/Mem pipeline outputs.
module ex_stage #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter logic [31:0] RESET_PC    = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_id_to_ex,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] imm32,
  input  logic [3:0]  alu_op,
  input  logic        alu_src_imm,
  input  logic [3:0]  md_op,
  input  logic        ov_en,
  input  logic [1:0]  ov_kind,
  input  logic [1:0]  fwd_rs_sel,
  input  logic [1:0]  fwd_rt_sel,
  input  logic [31:0] fwd_mem,
  input  logic [31:0] fwd_wb,
  input  logic [4:0]  waddr_id_to_ex,
  input  logic [2:0]  tnew_id_to_ex,
  input  logic        err_id_to_ex,
  input  logic [4:0]  errstat_id_to_ex,
  input  logic        flush_ex,
  output logic        md_stall,
  output logic [31:0] alu_out_ex_to_mem,
  output logic [31:0] dm_wdata_ex_to_mem,
  output logic [31:0] pc_ex_to_mem,
  output logic [4:0]  waddr_ex_to_mem,
  output logic [2:0]  tnew_ex_to_mem,
  output logic        err_ex_to_mem,
  output logic [4:0]  errstat_ex_to_mem
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB  = 4'd1,  ALU_OR   = 4'd2,  ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4,  ALU_NOR  = 4'd5,  ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8,  ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_SLLV = 4'd11;
  localparam logic [3:0] ALU_SRLV = 4'd12, ALU_SRAV = 4'd13, ALU_LUI = 4'd14;

  localparam logic [3:0] MD_MULT = 4'd1, MD_MULTU = 4'd2, MD_DIV  = 4'd3, MD_DIVU = 4'd4;
  localparam logic [3:0] MD_MFHI = 4'd5, MD_MFLO  = 4'd6, MD_MTHI = 4'd7, MD_MTLO = 4'd8;

  logic [31:0] opa, rt_fwd, opb, sum, diff, alu_res, alu_d;
  logic [4:0]  shamt, vsh;
  logic        add_ov, sub_ov, ov_hit, err_d;
  logic [4:0]  ov_code, errstat_d;
  logic [2:0]  tnew_d;
  logic        is_md, start, hi_wr, lo_wr;
  logic [63:0] smul, umul;
  logic [31:0] div_b, sdiv_quo, sdiv_rem, udiv_quo, udiv_rem;
  logic [31:0] md_hi_d, md_lo_d;

  logic [31:0] alu_q, wdata_q, pc_q;
  logic [4:0]  waddr_q, errstat_q;
  logic [2:0]  tnew_q;
  logic        err_q;
  logic [31:0] hi_q, lo_q, hi_sh_q, lo_sh_q;
  logic        commit_q, busy_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    case (fwd_rs_sel)
      2'd1:    opa = fwd_mem;
      2'd2:    opa = fwd_wb;
      default: opa = rs_val;
    endcase
    case (fwd_rt_sel)
      2'd1:    rt_fwd = fwd_mem;
      2'd2:    rt_fwd = fwd_wb;
      default: rt_fwd = rt_val;
    endcase
  end

  assign opb   = alu_src_imm ? imm32 : rt_fwd;
  assign sum   = opa + opb;
  assign diff  = opa - opb;
  assign shamt = imm32[10:6];
  assign vsh   = opa[4:0];

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      ALU_ADD:  alu_res = sum;
      ALU_SUB:  alu_res = diff;
      ALU_OR:   alu_res = opa | opb;
      ALU_AND:  alu_res = opa & opb;
      ALU_XOR:  alu_res = opa ^ opb;
      ALU_NOR:  alu_res = ~(opa | opb);
      ALU_SLT:  alu_res = {31'd0, $signed(opa) < $signed(opb)};
      ALU_SLTU: alu_res = {31'd0, opa < opb};
      ALU_SLL:  alu_res = opb << shamt;
      ALU_SRL:  alu_res = opb >> shamt;
      ALU_SRA:  alu_res = $signed(opb) >>> shamt;
      ALU_SLLV: alu_res = opb << vsh;
      ALU_SRLV: alu_res = opb >> vsh;
      ALU_SRAV: alu_res = $signed(opb) >>> vsh;
      ALU_LUI:  alu_res = {imm32[15:0], 16'd0};
      default:  alu_res = opb;
    endcase
  end

  // Signed overflow: operands agree in sign (add) or differ (sub) and the result flips it.
  assign add_ov = (opa[31] == opb[31]) && (sum[31] != opa[31]);
  assign sub_ov = (opa[31] != opb[31]) && (diff[31] != opa[31]);
  assign ov_hit = ov_en && (((alu_op == ALU_ADD) && add_ov) || ((alu_op == ALU_SUB) && sub_ov));

  always_comb begin
    case (ov_kind)
      2'd1:    ov_code = 5'd4;
      2'd2:    ov_code = 5'd5;
      default: ov_code = 5'd12;
    endcase
  end

  assign err_d     = err_id_to_ex | ov_hit;
  assign errstat_d = err_id_to_ex ? errstat_id_to_ex : (ov_hit ? ov_code : 5'd0);
  assign tnew_d    = (tnew_id_to_ex != 3'd0) ? tnew_id_to_ex - 3'd1 : 3'd0;

  always_comb begin
    alu_d = alu_res;
    if (md_op == MD_MFHI)      alu_d = hi_q;
    else if (md_op == MD_MFLO) alu_d = lo_q;
  end

  assign is_md    = (md_op >= MD_MULT) && (md_op <= MD_DIVU);
  assign start    = is_md && !busy_q && !flush_ex && !err_d;
  assign md_stall = start | busy_q;
  assign hi_wr    = (md_op == MD_MTHI) && !flush_ex && !err_id_to_ex;
  assign lo_wr    = (md_op == MD_MTLO) && !flush_ex && !err_id_to_ex;

  // Divisor forced to 1 on zero only to keep the datapath defined; such a result is never committed.
  assign div_b    = (rt_fwd == 32'd0) ? 32'd1 : rt_fwd;
  assign smul     = {{32{opa[31]}}, opa} * {{32{rt_fwd[31]}}, rt_fwd};
  assign umul     = {32'd0, opa} * {32'd0, rt_fwd};
  assign sdiv_quo = $signed(opa) / $signed(div_b);
  assign sdiv_rem = $signed(opa) % $signed(div_b);
  assign udiv_quo = opa / div_b;
  assign udiv_rem = opa % div_b;

  always_comb begin
    md_hi_d = 32'd0;
    md_lo_d = 32'd0;
    case (md_op)
      MD_MULT:  begin md_hi_d = smul[63:32]; md_lo_d = smul[31:0]; end
      MD_MULTU: begin md_hi_d = umul[63:32]; md_lo_d = umul[31:0]; end
      MD_DIV:   begin md_hi_d = sdiv_rem;    md_lo_d = sdiv_quo;   end
      MD_DIVU:  begin md_hi_d = udiv_rem;    md_lo_d = udiv_quo;   end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q     <= 32'd0;
      wdata_q   <= 32'd0;
      pc_q      <= RESET_PC;
      waddr_q   <= 5'd0;
      tnew_q    <= 3'd0;
      err_q     <= 1'b0;
      errstat_q <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      hi_sh_q   <= 32'd0;
      lo_sh_q   <= 32'd0;
      commit_q  <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_q <= pc_id_to_ex;
      if (flush_ex) begin
        alu_q     <= 32'd0;
        wdata_q   <= 32'd0;
        waddr_q   <= 5'd0;
        tnew_q    <= 3'd0;
        err_q     <= 1'b0;
        errstat_q <= 5'd0;
      end else begin
        alu_q     <= alu_d;
        wdata_q   <= rt_fwd;
        waddr_q   <= waddr_id_to_ex;
        tnew_q    <= tnew_d;
        err_q     <= err_d;
        errstat_q <= errstat_d;
      end

      if (start) begin
        busy_q   <= 1'b1;
        cnt_q    <= (md_op == MD_MULT || md_op == MD_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        hi_sh_q  <= md_hi_d;
        lo_sh_q  <= md_lo_d;
        commit_q <= !((md_op == MD_DIV || md_op == MD_DIVU) && rt_fwd == 32'd0);
      end else if (busy_q) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          if (commit_q) begin
            hi_q <= hi_sh_q;
            lo_q <= lo_sh_q;
          end
        end
      end

      // Explicit moves come later in program order than any in-flight result.
      if (hi_wr) hi_q <= opa;
      if (lo_wr) lo_q <= opa;
    end
  end

  assign alu_out_ex_to_mem  = alu_q;
  assign dm_wdata_ex_to_mem = wdata_q;
  assign pc_ex_to_mem       = pc_q;
  assign waddr_ex_to_mem    = waddr_q;
  assign tnew_ex_to_mem     = tnew_q;
  assign err_ex_to_mem      = err_q;
  assign errstat_ex_to_mem  = errstat_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed instructions push expectations, a monitor
// pops one entry per cycle and compares md_stall and the registered EX/Mem outputs.
module tb_ex_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc_id_to_ex, rs_val, rt_val, imm32, fwd_mem, fwd_wb;
  logic [3:0]  alu_op, md_op;
  logic        alu_src_imm, ov_en, err_id_to_ex, flush_ex;
  logic [1:0]  ov_kind, fwd_rs_sel, fwd_rt_sel;
  logic [4:0]  waddr_id_to_ex, errstat_id_to_ex;
  logic [2:0]  tnew_id_to_ex;
  logic        md_stall;
  logic [31:0] alu_out_ex_to_mem, dm_wdata_ex_to_mem, pc_ex_to_mem;
  logic [4:0]  waddr_ex_to_mem, errstat_ex_to_mem;
  logic [2:0]  tnew_ex_to_mem;
  logic        err_ex_to_mem;

  ex_stage dut (
    .clk(clk), .reset(reset), .pc_id_to_ex(pc_id_to_ex), .rs_val(rs_val), .rt_val(rt_val),
    .imm32(imm32), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .md_op(md_op), .ov_en(ov_en),
    .ov_kind(ov_kind), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .fwd_mem(fwd_mem),
    .fwd_wb(fwd_wb), .waddr_id_to_ex(waddr_id_to_ex), .tnew_id_to_ex(tnew_id_to_ex),
    .err_id_to_ex(err_id_to_ex), .errstat_id_to_ex(errstat_id_to_ex), .flush_ex(flush_ex),
    .md_stall(md_stall), .alu_out_ex_to_mem(alu_out_ex_to_mem),
    .dm_wdata_ex_to_mem(dm_wdata_ex_to_mem), .pc_ex_to_mem(pc_ex_to_mem),
    .waddr_ex_to_mem(waddr_ex_to_mem), .tnew_ex_to_mem(tnew_ex_to_mem),
    .err_ex_to_mem(err_ex_to_mem), .errstat_ex_to_mem(errstat_ex_to_mem)
  );

  typedef struct {
    string       nm;
    bit          cs;  logic        s;
    bit          ca;  logic [31:0] a;
    bit          cw;  logic [31:0] w;
    bit          cm;  logic [31:0] pc; logic [4:0] wa; logic [2:0] tn; logic e; logic [4:0] ec;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] pc_ctr;
  logic [31:0] cur_pc;
  int          checks;
  int          failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  function automatic exp_t blank(input string nm);
    exp_t x;
    x.nm = nm; x.cs = 0; x.s = 0; x.ca = 0; x.a = 0; x.cw = 0; x.w = 0;
    x.cm = 0; x.pc = 0; x.wa = 0; x.tn = 0; x.e = 0; x.ec = 0;
    return x;
  endfunction

  task automatic chk(input string txn, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", txn, fld, act, req);
    end
  endtask

  task automatic clr();
    reset = 0; rs_val = 0; rt_val = 0; imm32 = 0; alu_op = 0; alu_src_imm = 0; md_op = 0;
    ov_en = 0; ov_kind = 0; fwd_rs_sel = 0; fwd_rt_sel = 0; fwd_mem = 0; fwd_wb = 0;
    waddr_id_to_ex = 0; tnew_id_to_ex = 0; err_id_to_ex = 0; errstat_id_to_ex = 0; flush_ex = 0;
    pc_id_to_ex = pc_ctr; cur_pc = pc_ctr; pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic tick(input string nm);
    @(negedge clk);
    clr();
    cur = blank(nm);
  endtask

  task automatic es(input logic s);            cur.cs = 1; cur.s = s; endtask
  task automatic ea(input logic [31:0] a);     cur.ca = 1; cur.a = a; endtask
  task automatic ew(input logic [31:0] w);     cur.cw = 1; cur.w = w; endtask
  task automatic em(input logic [4:0] wa, input logic [2:0] tn, input logic e, input logic [4:0] ec);
    cur.cm = 1; cur.pc = cur_pc; cur.wa = wa; cur.tn = tn; cur.e = e; cur.ec = ec;
  endtask
  task automatic fire(); q.push_back(cur); endtask

  task automatic idle(input string nm, input int n, input bit cks, input logic s);
    for (int i = 0; i < n; i++) begin
      tick(nm);
      if (cks) es(s);
      fire();
    end
  endtask

  task automatic mf(input string nm, input logic [3:0] op, input logic [31:0] val);
    tick(nm); md_op = op; waddr_id_to_ex = 5'd2; tnew_id_to_ex = 3'd1;
    es(0); ea(val); em(5'd2, 3'd0, 0, 5'd0); fire();
  endtask

  // Monitor: stall is checked for the current entry, registered outputs for the previous one.
  initial begin
    exp_t c;
    exp_t p;
    p = blank("none");
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) c = q.pop_front();
      else c = blank("idle");
      if (c.cs) chk(c.nm, "md_stall", 32'(md_stall), 32'(c.s));
      if (p.ca) chk(p.nm, "alu_out", alu_out_ex_to_mem, p.a);
      if (p.cw) chk(p.nm, "dm_wdata", dm_wdata_ex_to_mem, p.w);
      if (p.cm) begin
        chk(p.nm, "pc", pc_ex_to_mem, p.pc);
        chk(p.nm, "waddr", 32'(waddr_ex_to_mem), 32'(p.wa));
        chk(p.nm, "tnew", 32'(tnew_ex_to_mem), 32'(p.tn));
        chk(p.nm, "err", 32'(err_ex_to_mem), 32'(p.e));
        chk(p.nm, "errstat", 32'(errstat_ex_to_mem), 32'(p.ec));
      end
      if (p.ca || p.cw || p.cm || p.cs) $display("txn %s checked", p.nm);
      p = c;
    end
  end

  initial begin
    checks = 0; failures = 0; pc_ctr = 32'h0000_4000;
    clr();
    reset = 1;

    tick("reset"); reset = 1; es(0); ea(0); ew(0);
    em(5'd0, 3'd0, 0, 5'd0); cur.pc = 32'h0000_3000; fire();

    tick("add_ov_arith"); rs_val = 32'h7FFF_FFFF; rt_val = 32'd1; ov_en = 1;
    waddr_id_to_ex = 5'd5; tnew_id_to_ex = 3'd2;
    es(0); ea(32'h8000_0000); ew(32'd1); em(5'd5, 3'd1, 1, 5'd12); fire();

    tick("add_ov_upstream"); rs_val = 32'h7FFF_FFFF; rt_val = 32'd1; ov_en = 1;
    err_id_to_ex = 1; errstat_id_to_ex = 5'd10; waddr_id_to_ex = 5'd5;
    ea(32'h8000_0000); em(5'd5, 3'd0, 1, 5'd10); fire();

    tick("addi_ov_load"); rs_val = 32'h7FFF_FFFF; imm32 = 32'd1; alu_src_imm = 1;
    ov_en = 1; ov_kind = 2'd1; waddr_id_to_ex = 5'd6;
    ea(32'h8000_0000); ew(32'd0); em(5'd6, 3'd0, 1, 5'd4); fire();

    tick("sub_ov_store"); rs_val = 32'h8000_0000; rt_val = 32'd1; alu_op = 4'd1;
    ov_en = 1; ov_kind = 2'd2;
    ea(32'h7FFF_FFFF); ew(32'd1); em(5'd0, 3'd0, 1, 5'd5); fire();

    tick("add_no_ov_en"); rs_val = 32'h7FFF_FFFF; rt_val = 32'd1;
    ea(32'h8000_0000); em(5'd0, 3'd0, 0, 5'd0); fire();

    tick("fwd_sub"); rs_val = 32'd100; rt_val = 32'd200; alu_op = 4'd1;
    fwd_rs_sel = 2'd1; fwd_mem = 32'd5; fwd_rt_sel = 2'd2; fwd_wb = 32'd3;
    ea(32'd2); ew(32'd3); fire();

    tick("slt"); rs_val = 32'hFFFF_FFFF; rt_val = 32'd1; alu_op = 4'd6;
    waddr_id_to_ex = 5'd9; tnew_id_to_ex = 3'd7;
    ea(32'd1); em(5'd9, 3'd6, 0, 5'd0); fire();

    tick("sltu"); rs_val = 32'hFFFF_FFFF; rt_val = 32'd1; alu_op = 4'd7; ea(32'd0); fire();
    tick("sra");  rt_val = 32'h8000_0000; imm32 = 32'h0000_0100; alu_op = 4'd10; ea(32'hF800_0000); fire();
    tick("sllv"); rs_val = 32'h0000_0023; rt_val = 32'd1; alu_op = 4'd11; ea(32'd8); fire();
    tick("lui");  imm32 = 32'h0000_1234; alu_src_imm = 1; alu_op = 4'd14; ea(32'h1234_0000); fire();
    tick("nor");  alu_op = 4'd5; ea(32'hFFFF_FFFF); fire();

    tick("mult_err_blocked"); md_op = 4'd1; rs_val = 32'd9; rt_val = 32'd9;
    err_id_to_ex = 1; errstat_id_to_ex = 5'd3;
    es(0); em(5'd0, 3'd0, 1, 5'd3); fire();
    idle("after_err_mult", 1, 1, 0);

    tick("mult_start"); md_op = 4'd1; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2; es(1); fire();
    idle("mult_busy", 4, 1, 1);
    mf("mfhi_before_commit", 4'd5, 32'd0);
    cur.s = 1;
    q[q.size()-1].s = 1;
    mf("mfhi_mult", 4'd5, 32'hFFFF_FFFF);
    mf("mflo_mult", 4'd6, 32'hFFFF_FFFE);

    tick("multu_start"); md_op = 4'd2; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2; es(1); fire();
    idle("multu_busy", 5, 1, 1);
    mf("mfhi_multu", 4'd5, 32'd1);
    mf("mflo_multu", 4'd6, 32'hFFFF_FFFE);

    tick("div_start"); md_op = 4'd3; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2; es(1); fire();
    idle("div_busy", 10, 1, 1);
    mf("mflo_div", 4'd6, 32'hFFFF_FFFD);
    mf("mfhi_div", 4'd5, 32'hFFFF_FFFF);

    tick("divu_zero_start"); md_op = 4'd4; rs_val = 32'd5; rt_val = 32'd0; es(1); fire();
    idle("divu_zero_busy", 10, 1, 1);
    mf("mfhi_divz", 4'd5, 32'hFFFF_FFFF);
    mf("mflo_divz", 4'd6, 32'hFFFF_FFFD);

    tick("mthi"); md_op = 4'd7; rs_val = 32'hAAAA_5555; es(0); fire();
    tick("mtlo"); md_op = 4'd8; rs_val = 32'h1234_5678; es(0); fire();
    tick("mthi_flushed"); md_op = 4'd7; rs_val = 32'h0000_DEAD; flush_ex = 1;
    waddr_id_to_ex = 5'd4; em(5'd0, 3'd0, 0, 5'd0); fire();
    mf("mfhi_mt", 4'd5, 32'hAAAA_5555);
    mf("mflo_mt", 4'd6, 32'h1234_5678);

    tick("div_flushed"); md_op = 4'd3; rs_val = 32'd10; rt_val = 32'd3; flush_ex = 1;
    waddr_id_to_ex = 5'd7; tnew_id_to_ex = 3'd3;
    es(0); em(5'd0, 3'd0, 0, 5'd0); fire();
    idle("after_div_flush", 1, 1, 0);
    mf("mflo_after_flush", 4'd6, 32'h1234_5678);

    tick("mult_inflight_start"); md_op = 4'd1; rs_val = 32'h0001_0000; rt_val = 32'h0003_0004;
    es(1); fire();
    tick("flush_inflight"); flush_ex = 1; waddr_id_to_ex = 5'd9; err_id_to_ex = 1; errstat_id_to_ex = 5'd10;
    es(1); em(5'd0, 3'd0, 0, 5'd0); fire();
    idle("inflight_busy", 4, 1, 1);
    mf("mfhi_inflight", 4'd5, 32'h0000_0003);
    mf("mflo_inflight", 4'd6, 32'h0004_0000);

    tick("mult_abort_start"); md_op = 4'd1; rs_val = 32'd7; rt_val = 32'd7; es(1); fire();
    idle("abort_busy", 2, 1, 1);
    tick("reset_mid_mdu"); reset = 1; waddr_id_to_ex = 5'd3; es(1); ea(0);
    em(5'd0, 3'd0, 0, 5'd0); cur.pc = 32'h0000_3000; fire();
    idle("after_reset", 1, 1, 0);
    mf("mflo_after_reset", 4'd6, 32'd0);
    mf("mfhi_after_reset", 4'd5, 32'd0);
    idle("post_reset_wait", 4, 1, 0);
    mf("mflo_no_late_commit", 4'd6, 32'd0);

    idle("drain", 3, 0, 0);
    @(negedge clk);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, between ID/EX and the memory stage.
- Selects forwarded operands and computes the ALU result.
- Runs the multi-cycle multiply/divide unit (HI/LO) with busy/stall signalling.
- Detects integer overflow and registers the EX/Mem pipeline outputs the memory stage consumes.

Parameters:
- MULT_CYCLES, 5: busy duration of mult/multu.
- DIV_CYCLES, 10: busy duration of div/divu.
- RESET_PC, 32'h0000_3000: PC value loaded into the pipeline register on reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- pc_id_to_ex  in  32  PC of the instruction in EX
- rs_val, rt_val  in  32 each  register operands from ID/EX
- imm32  in  32  extended immediate; shamt = imm32[10:6]
- alu_op  in  4  0 add,1 sub,2 or,3 and,4 xor,5 nor,6 slt,7 sltu,8 sll,9 srl,10 sra,11 sllv,12 srlv,13 srav,14 lui,15 passB
- alu_src_imm  in  1  ALU operand B = imm32 when 1, else forwarded rt
- md_op  in  4  0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo
- ov_en  in  1  enable signed-overflow check on add/sub
- ov_kind  in  2  0 arith (ExcCode 12), 1 load addr (4), 2 store addr (5)
- fwd_rs_sel, fwd_rt_sel  in  2 each  0 ID/EX value, 1 fwd_mem, 2 fwd_wb
- fwd_mem, fwd_wb  in  32 each  forwarded data
- waddr_id_to_ex  in  5  destination register
- tnew_id_to_ex  in  3  Tnew on entry to EX
- err_id_to_ex  in  1  exception already raised upstream
- errstat_id_to_ex  in  5  upstream ExcCode
- flush_ex  in  1  squash the EX instruction (exception/eret taken in Mem)
- md_stall  out  1  start | busy, consumed by the hazard unit
- alu_out_ex_to_mem  out  32  ALU result or HI/LO read value
- dm_wdata_ex_to_mem  out  32  forwarded rt value (store data)
- pc_ex_to_mem  out  32  PC
- waddr_ex_to_mem  out  5  destination register
- tnew_ex_to_mem  out  3  saturating Tnew-1
- err_ex_to_mem  out  1  exception flag
- errstat_ex_to_mem  out  5  ExcCode

Behaviour:
- Operand selection and the ALU are combinational. All outputs except md_stall are registered (1-cycle latency). md_stall is combinational.
- Reset values:
  - pc = RESET_PC; all other pipeline outputs = 0.
  - HI = LO = 0, busy = 0, counter = 0.
- Arithmetic:
  - All arithmetic is 32-bit wrap-around.
  - slt is signed; sltu is unsigned.
  - Variable shifts use only the low 5 bits of operand A.
  - lui = imm32 << 16.
- Overflow: when ov_en = 1 and alu_op is add/sub with signed overflow, set err = 1 and errstat = 12, 4 or 5 per ov_kind. An incoming err_id_to_ex takes priority and passes through unchanged.
- mfhi/mflo: alu_out = HI/LO as of the current cycle. mthi/mtlo write HI/LO at the clock edge.
- MDU start:
  - start = md_op in 1..4, not busy, not flush_ex, not err (incoming or overflow).
  - At the start edge, latch the result into shadow registers; load counter = MULT_CYCLES or DIV_CYCLES; set busy.
  - The counter decrements each cycle. At 1 -> 0, shadow results commit to HI/LO and busy clears.
  - HI/LO therefore become visible exactly MULT/DIV_CYCLES cycles after the start edge.
- Divide semantics: LO = quotient, HI = remainder, both truncated toward zero (signed: remainder takes the dividend's sign). Divide by zero commits nothing; HI/LO are unchanged but busy still runs the full DIV_CYCLES.
- mult result: HI:LO = 64-bit product (signed or unsigned per op).
- md_stall = start | busy. The hazard unit holds ID when ID carries any md_op while md_stall = 1.
- flush_ex = 1:
  - Pipeline register loads a bubble: waddr = 0, tnew = 0, err = 0; pc = pc_id_to_ex.
  - No start; no mthi/mtlo write.
  - An MDU operation already in flight continues and commits.
- Reset mid-operation aborts the MDU: busy = 0, HI/LO = 0, no commit.
- Tnew out = tnew_id_to_ex - 1 if > 0, else 0.

Test Plan:
- add 0x7FFFFFFF + 1 with ov_en = 1, ov_kind = 0 -> next cycle err = 1, errstat = 12, alu_out = 0x80000000; same with err_id_to_ex = 1 and errstat = 10 -> errstat = 10.
- mult 0xFFFFFFFF × 2 (signed) then mfhi/mflo -> md_stall high for 6 cycles (start + 5 busy); HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. multu with the same operands -> HI = 1, LO = 0xFFFFFFFE.
- div -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF after 10 cycles. divu 5 / 0 -> HI/LO unchanged, busy still lasts 10 cycles.
- Forwarding: fwd_rs_sel = 1 (fwd_mem = 5), fwd_rt_sel = 2 (fwd_wb = 3), sub -> alu_out = 2, dm_wdata = 3.
- flush_ex asserted with div in EX -> no busy, bubble output (waddr 0, err 0). flush_ex asserted during an in-flight mult -> mult still commits.
- Assert reset at busy counter = 3 -> busy = 0, HI = LO = 0, pc_ex_to_mem = 0x00003000 on the next cycle.
